// File: rtl/bram_arbiter.sv
// Two-requester arbiter in front of a single-port BRAM; round-robin by default.
// Define BRAM_ARB_FIXED_PRIO_EN to make requester 0 win every tie instead.
module bram_arbiter #(
  parameter logic [31:0] ADDR_LIMIT = 32'd8000
) (
  input  logic        clka,
  input  logic        resetn,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [1:0]  gnt,
  output logic [1:0]  rvalid,
  output logic [31:0] rdata,
  output logic [1:0]  err,
  output logic        busy,
  output logic [7:0]  err_cnt,
  output logic        bram_ena,
  output logic        bram_wea,
  output logic [31:0] bram_addra,
  output logic [31:0] bram_dina,
  input  logic [31:0] bram_douta
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACC = 2'd1, ST_RDW = 2'd2} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_gnt, r_rvalid, r_err;
  logic [1:0]  w_gnt_nxt, w_rvalid_nxt, w_err_nxt;
  logic        r_busy;
  logic [31:0] r_rdata;
  logic [7:0]  r_err_cnt;
  logic        r_ena, r_wea, w_ena_nxt, w_wea_nxt;
  logic [31:0] r_addra, r_dina;
  logic        r_win, r_we, r_oor;
  logic        w_win, w_take, w_rdata_ld, w_cnt_inc;
  logic [31:0] w_addr_sel, w_wdata_sel;
  logic        w_we_sel, w_in_range;

  function automatic logic [1:0] f_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

`ifdef BRAM_ARB_FIXED_PRIO_EN
  // Winner select: requester 1 only wins when it asks alone.
  always_comb begin
    w_win = 1'b0;
    case (req)
      2'b10:   w_win = 1'b1;
      default: w_win = 1'b0;
    endcase
  end
`else
  logic r_last;

  // Winner select: a tie goes to whoever did not win last time.
  always_comb begin
    w_win = 1'b0;
    case (req)
      2'b01:   w_win = 1'b0;
      2'b10:   w_win = 1'b1;
      2'b11:   w_win = ~r_last;
      default: w_win = 1'b0;
    endcase
  end

  // Last-winner pointer; reset value 1 lets requester 0 win the first tie.
  always_ff @(posedge clka or negedge resetn) begin
    if (!resetn) begin
      r_last <= 1'b1;
    end else if (w_take) begin
      r_last <= w_win;
    end
  end
`endif

  assign w_addr_sel  = w_win ? addr[63:32]  : addr[31:0];
  assign w_wdata_sel = w_win ? wdata[63:32] : wdata[31:0];
  assign w_we_sel    = w_win ? we[1]        : we[0];
  assign w_in_range  = (w_addr_sel < ADDR_LIMIT);

  // Next state and next values of the registered outputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = 2'b00;
    w_rvalid_nxt = 2'b00;
    w_err_nxt    = 2'b00;
    w_ena_nxt    = 1'b0;
    w_wea_nxt    = 1'b0;
    w_take       = 1'b0;
    w_rdata_ld   = 1'b0;
    w_cnt_inc    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req != 2'b00) begin
          w_take      = 1'b1;
          w_state_nxt = ST_ACC;
          w_gnt_nxt   = f_onehot(w_win);
          w_ena_nxt   = w_in_range;
          w_wea_nxt   = w_in_range & w_we_sel;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (r_oor) begin
          w_err_nxt   = f_onehot(r_win);
          w_cnt_inc   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_we) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RDW;
        end
      end
      ST_RDW: begin
        w_rvalid_nxt = f_onehot(r_win);
        w_rdata_ld   = 1'b1;
        w_state_nxt  = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, latched request and all output registers.
  always_ff @(posedge clka or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_gnt     <= 2'b00;
      r_rvalid  <= 2'b00;
      r_err     <= 2'b00;
      r_busy    <= 1'b0;
      r_rdata   <= 32'd0;
      r_err_cnt <= 8'd0;
      r_ena     <= 1'b0;
      r_wea     <= 1'b0;
      r_addra   <= 32'd0;
      r_dina    <= 32'd0;
      r_win     <= 1'b0;
      r_we      <= 1'b0;
      r_oor     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_rvalid <= w_rvalid_nxt;
      r_err    <= w_err_nxt;
      r_busy   <= (w_state_nxt != ST_IDLE);
      r_ena    <= w_ena_nxt;
      r_wea    <= w_wea_nxt;
      if (w_take) begin
        r_win   <= w_win;
        r_we    <= w_we_sel;
        r_oor   <= ~w_in_range;
        r_addra <= w_addr_sel;
        r_dina  <= w_wdata_sel;
      end
      if (w_rdata_ld) begin
        r_rdata <= bram_douta;
      end
      if (w_cnt_inc && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign gnt        = r_gnt;
  assign rvalid     = r_rvalid;
  assign err        = r_err;
  assign busy       = r_busy;
  assign rdata      = r_rdata;
  assign err_cnt    = r_err_cnt;
  assign bram_ena   = r_ena;
  assign bram_wea   = r_wea;
  assign bram_addra = r_addra;
  assign bram_dina  = r_dina;

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_LIMIT, default 8000, number of valid words; word addresses >= ADDR_LIMIT are out of range.
REQ-002 SHALL have ports: clka  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have ports: resetn  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports: req  in  2  per-requester access request, bit i = requester i.
REQ-005 SHALL have ports: we  in  2  per-requester write enable (1 = write, 0 = read).
REQ-006 SHALL have ports: addr  in  64  packed word addresses {addr1[31:0], addr0[31:0]}.
REQ-007 SHALL have ports: wdata  in  64  packed write data {wdata1, wdata0}.
REQ-008 SHALL have ports: gnt  out  2  one-cycle grant pulse, bit i = requester i.
REQ-009 SHALL have ports: rvalid  out  2  one-cycle read-data-valid pulse per requester.
REQ-010 SHALL have ports: rdata  out  32  read data, shared by both requesters.
REQ-011 SHALL have ports: err  out  2  one-cycle out-of-range pulse per requester.
REQ-012 SHALL have ports: busy  out  1  high whenever state is not IDLE.
REQ-013 SHALL have ports: err_cnt  out  8  saturating count of out-of-range accesses.
REQ-014 SHALL have ports: bram_ena, bram_wea  out  1 each  memory enable / write enable.
REQ-015 SHALL have ports: bram_addra, bram_dina  out  32 each  memory address / write data.
REQ-016 SHALL have ports: bram_douta  in  32  memory read data, valid one cycle after the enabled edge.

Function
REQ-017 SHALL implement states IDLE, ACC, RDW; all outputs SHALL be registered.
REQ-018 IDLE: if req != 0, SHALL pick a winner w, latch we/addr/wdata of w, pulse gnt[w] during the next cycle, go to ACC.
REQ-019 Requesters SHALL hold req/we/addr/wdata stable until gnt seen; IDLE SHALL re-sample req only in the cycle after ACC (or after RDW).
REQ-020 Arbitration default: round-robin; when both request, grant goes to the requester not granted last; last-winner pointer resets to 1 (requester 0 wins first).
REQ-021 Single request SHALL be granted regardless of pointer; pointer updates on every grant.
REQ-022 ACC, in range: bram_ena=1, bram_wea=latched we, bram_addra=latched addr, bram_dina=latched wdata, for exactly this one cycle.
REQ-023 ACC, write: next state IDLE; write occupancy 2 cycles (IDLE, ACC).
REQ-024 ACC, read: next state RDW; in RDW bram_ena=0, rdata <= bram_douta at end of RDW, rvalid[w] high the following cycle, next state IDLE.
REQ-025 Read latency: gnt cycle N, rvalid and rdata valid cycle N+2; rdata SHALL hold until the next read completes.
REQ-026 ACC, out of range (addr >= ADDR_LIMIT): bram_ena=0, err[w] pulses the next cycle, no rvalid, next state IDLE, err_cnt +1 saturating at 255.
REQ-027 bram_ena, bram_wea SHALL be 0 in IDLE and RDW; gnt, rvalid, err SHALL never have more than one bit set.
REQ-028 Request dropped before grant SHALL be ignored; no access issued.

Reset
REQ-029 resetn low SHALL immediately force: state IDLE, gnt=0, rvalid=0, err=0, busy=0, rdata=0, err_cnt=0, bram_ena=0, bram_wea=0, bram_addra=0, bram_dina=0, pointer=1.
REQ-030 Reset during ACC or RDW SHALL abandon the access: no rvalid, no err, no counter change after release.
REQ-031 First grant SHALL be possible in the second clka edge after resetn deasserts.

Configuration
REQ-032 Macro BRAM_ARB_FIXED_PRIO_EN defined: requester 0 SHALL always win when both request; pointer unused.
REQ-033 Macro undefined: round-robin per REQ-020.

Verification
REQ-034 Requester 0 writes 0xDEADBEEF to addr 4, then reads addr 4 -> gnt[0] pulses, bram_wea=1 one cycle, rvalid[0] two cycles after read gnt, rdata=0xDEADBEEF.
REQ-035 req=2'b11 held, both reads, 4 consecutive grants -> gnt order 0,1,0,1 (with BRAM_ARB_FIXED_PRIO_EN: 0,0,0,0).
REQ-036 Requester 1 reads addr 8000 -> bram_ena stays 0, err[1] one pulse, err_cnt=1, no rvalid.
REQ-037 300 out-of-range accesses -> err_cnt=255, stays 255.
REQ-038 resetn low during RDW of a read -> no rvalid afterwards, all outputs at reset values, next request served normally.
